// File: rtl/fifo_drain.sv
// fifo_drain: FIFO read-side consumer with a 2-entry skid buffer.
// Issues read strobes, absorbs the one-cycle read latency, streams words out.
module fifo_drain #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic                   fifo_ren,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] drained_count,
  output logic                   busy
);

  logic [1:0]            occ;
  logic                  pending;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic [2:0]            level;

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign pop       = out_valid & out_ready;
  assign busy      = out_valid | pending;

  // Occupancy once the in-flight word lands and this cycle's pop leaves.
  assign level = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};

  assign fifo_ren = !RST & enable & !fifo_empty & (level < 3'd2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ           <= 2'd0;
      pending       <= 1'b0;
      buf0          <= '0;
      buf1          <= '0;
      drained_count <= '0;
    end else begin
      pending <= fifo_ren;
      if (pop)
        drained_count <= drained_count + COUNT_WIDTH'(1);
      unique case (1'b1)
        (occ == 2'd0) && pending: begin
          buf0 <= fifo_rdata;
          occ  <= 2'd1;
        end
        (occ == 2'd1) && pending && !pop: begin
          buf1 <= fifo_rdata;
          occ  <= 2'd2;
        end
        (occ == 2'd1) && pending && pop: begin
          buf0 <= fifo_rdata;
        end
        (occ == 2'd1) && !pending && pop: begin
          occ <= 2'd0;
        end
        (occ == 2'd2) && !pending && pop: begin
          buf0 <= buf1;
          occ  <= 2'd1;
        end
        (occ == 2'd2) && pending && pop: begin
          buf0 <= buf1;
          buf1 <= fifo_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed bench for fifo_drain.
// A behavioural FIFO feeds the DUT; a monitor records strobes and pops.
module tb_fifo_drain;

  logic        CLK;
  logic        RST;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_ren;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [15:0] drained_count;
  logic        busy;

  logic        ren4;
  logic        valid4;
  logic [7:0]  data4;
  logic [3:0]  count4;
  logic        busy4;

  fifo_drain #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .drained_count(drained_count), .busy(busy)
  );

  fifo_drain #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RST(RST), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(ren4), .out_valid(valid4),
    .out_data(data4), .out_ready(out_ready),
    .drained_count(count4), .busy(busy4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  initial fifo_rdata = 8'h00;
  always @(posedge CLK) begin
    if (fifo_ren) begin
      fifo_rdata <= mem[rp];
      rp <= rp + 1;
    end
  end

  logic       mon_clr = 1'b0;
  int         ren_cnt = 0;
  int         ren_run = 0;
  int         ren_max = 0;
  int         pop_run = 0;
  int         pop_max = 0;
  int         rec_n   = 0;
  int         illegal = 0;
  logic [7:0] rec [0:63];

  always @(posedge CLK) begin
    if (!RST && dut.occ == 2'd2 && dut.pending && !(out_valid && out_ready))
      illegal <= illegal + 1;
    if (fifo_ren && fifo_empty)
      illegal <= illegal + 1;
    if (ren4 != fifo_ren || valid4 != out_valid || data4 != out_data)
      illegal <= illegal + 1;
    if (mon_clr) begin
      ren_cnt <= 0;
      ren_run <= 0;
      ren_max <= 0;
      pop_run <= 0;
      pop_max <= 0;
      rec_n   <= 0;
    end else begin
      if (fifo_ren) begin
        ren_cnt <= ren_cnt + 1;
        ren_run <= ren_run + 1;
        if (ren_run + 1 > ren_max) ren_max <= ren_run + 1;
      end else begin
        ren_run <= 0;
      end
      if (out_valid && out_ready) begin
        rec[rec_n] <= out_data;
        rec_n   <= rec_n + 1;
        pop_run <= pop_run + 1;
        if (pop_run + 1 > pop_max) pop_max <= pop_run + 1;
      end else begin
        pop_run <= 0;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    push(8'hA5);
    tick(2);
    chk("rst_ren", int'(fifo_ren), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_count", int'(drained_count), 0);
    chk("rst_busy", int'(busy), 0);

    RST = 1'b0;
    #1;
    chk("one_ren", int'(fifo_ren), 1);
    tick(1);
    chk("one_ren_off", int'(fifo_ren), 0);
    chk("one_valid_n1", int'(out_valid), 0);
    chk("one_busy_n1", int'(busy), 1);
    tick(1);
    chk("one_valid_n2", int'(out_valid), 1);
    chk("one_data", int'(out_data), 8'hA5);
    tick(1);
    chk("one_count", int'(drained_count), 1);
    chk("one_busy", int'(busy), 0);
    chk("one_rencnt", ren_cnt, 1);

    clr_mon();
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(14);
    chk("burst_rencnt", ren_cnt, 8);
    chk("burst_renrun", ren_max, 8);
    chk("burst_poprun", pop_max, 8);
    chk("burst_n", rec_n, 8);
    for (int i = 0; i < 8; i++) chk("burst_word", int'(rec[i]), i + 1);
    chk("burst_count", int'(drained_count), 9);

    clr_mon();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
    tick(6);
    chk("bp_rencnt", ren_cnt, 2);
    chk("bp_occ", int'(dut.occ), 2);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_data", int'(out_data), 8'h11);
    tick(3);
    chk("bp_hold", int'(out_data), 8'h11);
    out_ready = 1'b1;
    tick(10);
    chk("bp_n", rec_n, 5);
    chk("bp_poprun", pop_max, 5);
    for (int i = 0; i < 5; i++) chk("bp_word", int'(rec[i]), 8'h11 + i);
    chk("bp_count", int'(drained_count), 14);

    clr_mon();
    for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
    tick(2);
    enable = 1'b0;
    tick(6);
    chk("en_rencnt", ren_cnt, 2);
    chk("en_n", rec_n, 2);
    chk("en_w0", int'(rec[0]), 8'h21);
    chk("en_w1", int'(rec[1]), 8'h22);
    chk("en_busy", int'(busy), 0);
    chk("en_count", int'(drained_count), 16);

    out_ready = 1'b0;
    enable = 1'b1;
    tick(4);
    chk("mid_occ", int'(dut.occ), 2);
    chk("mid_data", int'(out_data), 8'h23);
    RST = 1'b1;
    mon_clr = 1'b1;
    tick(1);
    chk("mid_occ_rst", int'(dut.occ), 0);
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_count", int'(drained_count), 0);
    chk("mid_odata", int'(out_data), 0);
    RST = 1'b0;
    mon_clr = 1'b0;
    out_ready = 1'b1;
    tick(8);
    chk("mid_n", rec_n, 2);
    chk("mid_w0", int'(rec[0]), 8'h25);
    chk("mid_w1", int'(rec[1]), 8'h26);
    chk("mid_count2", int'(drained_count), 2);

    clr_mon();
    for (int i = 0; i < 15; i++) push(8'h30 + 8'(i));
    tick(25);
    chk("wrap_rencnt", ren_cnt, 15);
    chk("wrap_n", rec_n, 15);
    chk("wrap_last", int'(rec[14]), 8'h3E);
    chk("wrap_count16", int'(drained_count), 17);
    chk("wrap_count4", int'(count4), 1);
    chk("no_illegal", illegal, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side consumer for the team's FIFO. It issues read strobes into the FIFO read port, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words in FIFO order on a valid/ready stream. It sits between the FIFO read interface and any downstream sink. It sustains one word per cycle and never overflows its buffer under backpressure.

## Interface
- DATA_WIDTH, 8, width of FIFO words and output data
- COUNT_WIDTH, 16, width of the delivered-word counter
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- enable  in  1  when low, no new reads are issued; in-flight read still completes
- fifo_empty  in  1  FIFO empty flag (read side)
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_ren
- fifo_ren  out  1  read strobe to FIFO (combinational)
- out_valid  out  1  output word available
- out_data  out  DATA_WIDTH  output word (buffer head)
- out_ready  in  1  sink accepts word when out_valid & out_ready
- drained_count  out  COUNT_WIDTH  words delivered since reset, wraps modulo 2^COUNT_WIDTH
- busy  out  1  out_valid | read in flight

## Operation
- State:
  - occ (0..2): buffer occupancy
  - buf0 (head), buf1
  - pending: 1-bit flag, set when a read was issued last cycle
  - drained_count
- pop = out_valid & out_ready.
- fifo_ren = !RST & enable & !fifo_empty & (occ + pending - pop < 2).
  - This is the only combinational path from out_ready to fifo_ren. It is required for full throughput.
- pending <= fifo_ren.
- Capture: when pending = 1, fifo_rdata is written into the buffer this cycle.
- Buffer update per cycle, indexed by (occ, capture, pop):
  - occ 0, capture: buf0 <= rdata, occ -> 1
  - occ 1, capture, no pop: buf1 <= rdata, occ -> 2
  - occ 1, capture + pop: buf0 <= rdata, occ stays 1
  - occ 1, pop only: occ -> 0
  - occ 2, pop, no capture: buf0 <= buf1, occ -> 1
  - occ 2, pop + capture: buf0 <= buf1, buf1 <= rdata, occ stays 2
  - occ 2, capture, no pop: illegal. The ren rule prevents it; the bench asserts it never occurs.
- out_valid = (occ != 0); out_data = buf0.
- drained_count increments by 1 on every pop and wraps to 0 after all-ones.
- Words leave in exactly the order read from the FIFO. There is no drop and no duplicate.
- Deasserting enable blocks new reads only. Buffered and in-flight words still drain normally.

## Timing
- Reset (RST high at a rising edge) sets:
  - occ = 0, pending = 0, buf0 = buf1 = 0, drained_count = 0
  - out_valid = 0, out_data = 0, busy = 0
  - fifo_ren = 0 while RST is high
- Reset mid-operation: a word read in the cycle before reset is discarded, and buffered words are lost. No partial state survives.
- Latency, buffer empty: fifo_ren in cycle N, fifo_rdata valid in cycle N+1, out_valid in cycle N+2.
- Throughput: one word per cycle while the FIFO is non-empty, enable = 1 and out_ready = 1.
- Backpressure with out_ready held low: at most 2 reads are issued, then fifo_ren stays 0 until a pop.
- fifo_empty is sampled in the same cycle as fifo_ren. The block never strobes an empty FIFO.
- out_data and out_valid hold stable while out_valid & !out_ready.

## Test plan
- Reset: RST high 2 cycles with the FIFO holding data -> fifo_ren = 0, out_valid = 0, drained_count = 0, busy = 0.
- Single word: FIFO holds 0xA5, out_ready = 1 -> fifo_ren for 1 cycle, out_valid 2 cycles later with out_data = 0xA5, drained_count = 1.
- Burst: FIFO holds 0x01..0x08, out_ready = 1 -> 8 consecutive fifo_ren cycles, out_valid high 8 consecutive cycles with data 0x01..0x08 in order.
- Backpressure: 5 words queued, out_ready = 0 -> exactly 2 fifo_ren pulses and occ = 2 with out_data = first word. Then out_ready = 1 -> remaining 5 words delivered in order, no gap after refill.
- Enable and reset mid-stream:
  - enable dropped after the 2nd read of 6 -> no further fifo_ren; buffered words still delivered; busy falls to 0 when drained.
  - RST pulsed with occ = 2 -> everything returns to reset values; the next read delivers the FIFO's next word.
- Counter wrap: COUNT_WIDTH = 4, 17 words drained -> drained_count = 1.
